// File: rtl/ula_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : ula_muldiv_seq
// Brief    : Multi-cycle RV64M MUL/MULHU/DIVU/REMU sequencer. It has no
//            multiplier or divider of its own. Each cycle it drives the
//            shared ULA adder to do one step of shift-add multiplication or
//            restoring division.
// Revision : 1.0 - initial release
// ============================================================================
module ula_muldiv_seq #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inicio,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cancelar,
  output logic            pronto,
  output logic            ocupado,
  output logic            valido,
  output logic [BITS-1:0] resultado,
  output logic [BITS-1:0] ula_dina,
  output logic [BITS-1:0] ula_dinb,
  output logic            ula_subtraindo,
  output logic [1:0]      ula_operacao,
  output logic            ula_alu_src,
  input  logic [BITS-1:0] ula_dout,
  input  logic            ula_cout
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ITERA = 2'd1;
  localparam logic [1:0] ST_FIM   = 2'd2;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] pr;      // P (product high) for MUL*, R (remainder) for DIV*
  logic [BITS-1:0] q;       // multiplier shifting out / quotient shifting in
  logic [BITS-1:0] m;       // multiplicand or divisor
  logic [1:0]      op_q;

  logic [BITS-1:0] rs;
  logic            t;
  logic [BITS-1:0] pr_nxt;
  logic [BITS-1:0] q_nxt;
  logic [BITS-1:0] res_nxt;

  // The ULA stays in add/sub mode with dinb selected for the whole operation.
  assign ula_operacao = 2'b00;
  assign ula_alu_src  = 1'b0;

  assign pronto  = (state == ST_IDLE);
  assign ocupado = (state == ST_ITERA) || (state == ST_FIM);
  assign valido  = (state == ST_FIM);

  // One iteration step: drive the ULA and form the next P/R and Q from its outputs.
  always_comb begin
    ula_dina       = '0;
    ula_dinb       = '0;
    ula_subtraindo = 1'b0;
    rs             = {pr[BITS-2:0], q[BITS-1]};
    t              = 1'b0;
    pr_nxt         = pr;
    q_nxt          = q;
    if (state == ST_ITERA) begin
      if (!op_q[1]) begin
        // Shift-add: add M when the current multiplier bit is set, then
        // shift {carry, sum, Q} right by one.
        ula_dina = pr;
        ula_dinb = q[0] ? m : '0;
        pr_nxt   = {ula_cout, ula_dout[BITS-1:1]};
        q_nxt    = {ula_dout[0], q[BITS-1:1]};
      end else begin
        // Restoring division. The shifted remainder is BITS+1 wide, and its
        // top bit is R[BITS-1]. When that bit is set, Rs >= M always holds.
        ula_dina       = rs;
        ula_dinb       = m;
        ula_subtraindo = 1'b1;
        t              = pr[BITS-1] | ula_cout;
        pr_nxt         = t ? ula_dout : rs;
        q_nxt          = {q[BITS-2:0], t};
      end
    end
  end

  // Pick the result word from the values that the last step will produce.
  always_comb begin
    res_nxt = q_nxt;
    case (op_q)
      OP_MUL:   res_nxt = q_nxt;
      OP_MULHU: res_nxt = pr_nxt;
      OP_DIVU:  res_nxt = q_nxt;
      OP_REMU:  res_nxt = pr_nxt;
      default:  res_nxt = q_nxt;
    endcase
  end

  // Control FSM and datapath registers. resultado is loaded on FIM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pr        <= '0;
      q         <= '0;
      m         <= '0;
      op_q      <= '0;
      resultado <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inicio && !cancelar) begin
            op_q  <= op;
            m     <= b;
            pr    <= '0;
            q     <= a;
            cnt   <= '0;
            state <= ST_ITERA;
          end
        end
        ST_ITERA: begin
          if (cancelar) begin
            state <= ST_IDLE;
          end else begin
            pr  <= pr_nxt;
            q   <= q_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              resultado <= res_nxt;
              state     <= ST_FIM;
            end
          end
        end
        ST_FIM: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_muldiv_seq
// Brief    : Directed, table-driven bench for ula_muldiv_seq. It includes a
//            behavioural model of the ULA adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_muldiv_seq;

  localparam int BITS = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inicio = 1'b0;
  logic [1:0]      op = 2'd0;
  logic [BITS-1:0] a = '0;
  logic [BITS-1:0] b = '0;
  logic            cancelar = 1'b0;
  logic            pronto;
  logic            ocupado;
  logic            valido;
  logic [BITS-1:0] resultado;
  logic [BITS-1:0] ula_dina;
  logic [BITS-1:0] ula_dinb;
  logic            ula_subtraindo;
  logic [1:0]      ula_operacao;
  logic            ula_alu_src;
  logic [BITS-1:0] ula_dout;
  logic            ula_cout;

  ula_muldiv_seq #(.BITS(BITS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inicio         (inicio),
    .op             (op),
    .a              (a),
    .b              (b),
    .cancelar       (cancelar),
    .pronto         (pronto),
    .ocupado        (ocupado),
    .valido         (valido),
    .resultado      (resultado),
    .ula_dina       (ula_dina),
    .ula_dinb       (ula_dinb),
    .ula_subtraindo (ula_subtraindo),
    .ula_operacao   (ula_operacao),
    .ula_alu_src    (ula_alu_src),
    .ula_dout       (ula_dout),
    .ula_cout       (ula_cout)
  );

  // ULA adder model: sum, or dina + ~dinb + 1, with carry out
  always_comb begin
    {ula_cout, ula_dout} = {1'b0, ula_dina}
                         + {1'b0, (ula_subtraindo ? ~ula_dinb : ula_dinb)}
                         + {{BITS{1'b0}}, ula_subtraindo};
  end

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nvalid = 0;

  // Count every cycle in which valido is high.
  always @(posedge clk) if (valido) nvalid <= nvalid + 1;

  typedef struct {
    logic [1:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Start one operation and follow it to valido.
  // With hold set, inicio stays high (with other operands) through ITERA and
  // through the edge that leaves FIM.
  task automatic run_op(input logic [1:0] o, input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                        input logic [BITS-1:0] e, input bit hold, input string nm);
    int cyc;
    int nv0;
    logic [BITS-1:0] prev;
    bit busy_ok;
    bit stable_ok;
    cyc = 0;
    while (!pronto && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " ready"}, BITS'(pronto), BITS'(1));
    chk({nm, " ula idle"}, ula_dina | ula_dinb | BITS'(ula_subtraindo), '0);
    prev = resultado;
    nv0 = nvalid;
    op = o; a = x; b = y; inicio = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      op = ~o; a = y; b = x;
    end else begin
      inicio = 1'b0;
    end
    cyc = 1;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    while (!valido && cyc < BITS + 20) begin
      if (pronto || !ocupado) busy_ok = 1'b0;
      if (resultado !== prev) stable_ok = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " valido"}, BITS'(valido), BITS'(1));
    chk({nm, " latency"}, BITS'(cyc), BITS'(BITS + 1));
    chk({nm, " resultado"}, resultado, e);
    chk({nm, " busy"}, BITS'(busy_ok), BITS'(1));
    chk({nm, " result stable"}, BITS'(stable_ok), BITS'(1));
    @(posedge clk); #1;
    inicio = 1'b0;
    chk({nm, " pronto after"}, BITS'(pronto), BITS'(1));
    chk({nm, " valido one cycle"}, BITS'(valido), BITS'(0));
    chk({nm, " result held"}, resultado, e);
    chk({nm, " valido count"}, BITS'(nvalid - nv0), BITS'(1));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    logic [BITS-1:0] prev;

    vecs[0]  = '{2'd0, 64'd7, 64'd6, 64'd42};
    vecs[1]  = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[2]  = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3]  = '{2'd2, 64'd100, 64'd7, 64'd14};
    vecs[4]  = '{2'd3, 64'd100, 64'd7, 64'd2};
    vecs[5]  = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1};
    vecs[6]  = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE};
    vecs[7]  = '{2'd2, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{2'd3, 64'd1234, 64'd0, 64'd1234};
    vecs[9]  = '{2'd1, 64'h8000_0000_0000_0000, 64'd4, 64'd2};
    vecs[10] = '{2'd0, 64'h8000_0000_0000_0000, 64'd4, 64'd0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset resultado", resultado, '0);
    chk("reset valido", BITS'(valido), '0);
    chk("reset pronto", BITS'(pronto), BITS'(1));
    chk("reset ocupado", BITS'(ocupado), '0);
    chk("reset ula ctrl", BITS'({ula_operacao, ula_alu_src}), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // inicio held through ITERA and FIM must not start a second operation
    run_op(2'd0, 64'd3, 64'd7, 64'd21, 1'b1, "hold");
    nv0 = nvalid;
    repeat (BITS + 10) @(posedge clk);
    #1;
    chk("hold no extra valido", BITS'(nvalid - nv0), '0);
    chk("hold pronto", BITS'(pronto), BITS'(1));

    // cancelar together with inicio blocks the accept
    prev = resultado;
    op = 2'd2; a = 64'd100; b = 64'd7; inicio = 1'b1; cancelar = 1'b1;
    @(posedge clk); #1;
    chk("cancel blocks accept", BITS'(pronto), BITS'(1));
    cancelar = 1'b0;
    // accept the DIVU, then cancel it at cycle 10
    @(posedge clk); #1;
    inicio = 1'b0;
    nv0 = nvalid;
    repeat (9) @(posedge clk);
    #1;
    chk("cancel busy", BITS'(ocupado), BITS'(1));
    cancelar = 1'b1;
    @(posedge clk); #1;
    cancelar = 1'b0;
    chk("cancel pronto", BITS'(pronto), BITS'(1));
    chk("cancel ocupado", BITS'(ocupado), '0);
    chk("cancel resultado", resultado, prev);
    repeat (BITS + 10) @(posedge clk);
    #1;
    chk("cancel no valido", BITS'(nvalid - nv0), '0);
    chk("cancel resultado kept", resultado, prev);
    run_op(2'd0, 64'd3, 64'd5, 64'd15, 1'b0, "after cancel");

    // asynchronous reset in the middle of a MUL
    nv0 = nvalid;
    op = 2'd0; a = 64'd9; b = 64'd9; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset resultado", resultado, '0);
    chk("midreset valido", BITS'(valido), '0);
    chk("midreset pronto", BITS'(pronto), BITS'(1));
    chk("midreset ocupado", BITS'(ocupado), '0);
    chk("midreset ula", ula_dina | ula_dinb | BITS'(ula_subtraindo), '0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (BITS + 10) @(posedge clk);
    #1;
    chk("midreset no valido", BITS'(nvalid - nv0), '0);
    chk("midreset pronto after", BITS'(pronto), BITS'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
